// File: rtl/vseq_pkg.sv
// Shared constants for the vector MAC sequencer: state codes, default sizes
// and the counter-width helper.
package vseq_pkg;

  localparam int VSEQ_NREG_DEF = 10;
  localparam int VSEQ_DW_DEF   = 8;

  typedef logic [2:0] vseq_state_t;

  localparam vseq_state_t ST_IDLE  = 3'd0;
  localparam vseq_state_t ST_LOAD  = 3'd1;
  localparam vseq_state_t ST_MAC   = 3'd2;
  localparam vseq_state_t ST_DRAIN = 3'd3;
  localparam vseq_state_t ST_DONE  = 3'd4;

  // Counter width for indices 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vseq_onehot_dec.sv
// Index to one-hot decoder with enable; an inactive enable yields all zeros.
module vseq_onehot_dec #(
  parameter int N  = 10,
  parameter int IW = 4
) (
  input  logic          en,
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign onehot[gi] = en && (idx == IW'(gi));
  end

endmodule

// File: rtl/vec_mac_sequencer.sv
// Load/multiply/accumulate controller for the vector register datapath.
// Optional VSEQ_ABORT_EN adds an abort input that cancels a run in progress.
module vec_mac_sequencer
  import vseq_pkg::*;
#(
  parameter int NREG = VSEQ_NREG_DEF,
  parameter int DW   = VSEQ_DW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef VSEQ_ABORT_EN
  input  logic            abort,
`endif
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [DW-1:0]   next_in,
  output logic [NREG-1:0] load,
  output logic            mul_en,
  output logic [NREG-1:0] mul_sel_a,
  output logic [NREG-1:0] mul_sel_b,
  output logic            add_en,
  output logic            acc_clr,
  output logic            busy,
  output logic            done,
  output logic [2:0]      state
);

  localparam int NPAIR = NREG / 2;
  localparam int IW    = idx_width(NREG);
  localparam int KW    = idx_width(NPAIR);

  localparam logic [IW-1:0] IDX_LAST = IW'(NREG - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NPAIR - 1);

  if (((NREG % 2) != 0) || (NREG < 2)) begin : g_nreg_check
    $error("vec_mac_sequencer: NREG must be even and at least 2");
  end

  vseq_state_t   state_reg, state_next;
  logic [IW-1:0] idx_reg;
  logic [KW-1:0] k_reg;
  logic          add_en_reg;

  logic          abort_hit;
  logic          beat;
  logic          load_en;
  logic          mac_en;
  logic [IW-1:0] a_idx;
  logic [IW-1:0] b_idx;

`ifdef VSEQ_ABORT_EN
  assign abort_hit = abort && ((state_reg == ST_LOAD) || (state_reg == ST_MAC) ||
                               (state_reg == ST_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign beat = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE:  state_next = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        if (abort_hit)                      state_next = ST_IDLE;
        else if (beat && idx_reg == IDX_LAST) state_next = ST_MAC;
        else                                state_next = ST_LOAD;
      end
      ST_MAC: begin
        if (abort_hit)             state_next = ST_IDLE;
        else if (k_reg == K_LAST)  state_next = ST_DRAIN;
        else                       state_next = ST_MAC;
      end
      ST_DRAIN: state_next = abort_hit ? ST_IDLE : ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // An aborting MAC cycle issues nothing, so no stray add_en follows into IDLE.
  always_comb begin
    in_ready = 1'b0;
    load_en  = 1'b0;
    mac_en   = 1'b0;
    acc_clr  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      ST_IDLE: acc_clr = start;
      ST_LOAD: begin
        busy     = 1'b1;
        in_ready = !abort_hit;
        load_en  = in_valid && !abort_hit;
      end
      ST_MAC: begin
        busy   = 1'b1;
        mac_en = !abort_hit;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg    <= '0;
      k_reg      <= '0;
      add_en_reg <= 1'b0;
    end else begin
      add_en_reg <= mac_en;
      if (state_reg == ST_IDLE && start) begin
        idx_reg <= '0;
      end else if (beat) begin
        idx_reg <= idx_reg + 1'b1;
      end
      if (beat && idx_reg == IDX_LAST) begin
        k_reg <= '0;
      end else if (mac_en) begin
        k_reg <= k_reg + 1'b1;
      end
    end
  end

  // Pair k reads registers 2k and 2k+1.
  assign a_idx = IW'({k_reg, 1'b0});
  assign b_idx = a_idx | IW'(1);

  vseq_onehot_dec #(.N(NREG), .IW(IW)) u_load_dec (
    .en     (load_en),
    .idx    (idx_reg),
    .onehot (load)
  );

  vseq_onehot_dec #(.N(NREG), .IW(IW)) u_sel_a_dec (
    .en     (mac_en),
    .idx    (a_idx),
    .onehot (mul_sel_a)
  );

  vseq_onehot_dec #(.N(NREG), .IW(IW)) u_sel_b_dec (
    .en     (mac_en),
    .idx    (b_idx),
    .onehot (mul_sel_b)
  );

  assign mul_en  = mac_en;
  assign add_en  = add_en_reg;
  assign next_in = in_data;
  assign state   = state_reg;

endmodule

// File: tb/tb_vec_mac_sequencer.sv
// Scoreboard bench for vec_mac_sequencer with a behavioural datapath model.
module tb_vec_mac_sequencer;
  import vseq_pkg::*;

  localparam int NREG  = 10;
  localparam int DW    = 8;
  localparam int NPAIR = NREG / 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
`ifdef VSEQ_ABORT_EN
  logic            abort = 1'b0;
`endif
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready;
  logic [DW-1:0]   next_in;
  logic [NREG-1:0] load;
  logic            mul_en;
  logic [NREG-1:0] mul_sel_a;
  logic [NREG-1:0] mul_sel_b;
  logic            add_en;
  logic            acc_clr;
  logic            busy;
  logic            done;
  logic [2:0]      state;

  vec_mac_sequencer #(.NREG(NREG), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef VSEQ_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .next_in   (next_in),
    .load      (load),
    .mul_en    (mul_en),
    .mul_sel_a (mul_sel_a),
    .mul_sel_b (mul_sel_b),
    .add_en    (add_en),
    .acc_clr   (acc_clr),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [NREG-1:0] v);
    int r = 0;
    for (int j = 0; j < NREG; j++) if (v[j]) r = j;
    return r;
  endfunction

  // Datapath model driven only by the sequencer's control outputs.
  logic [DW-1:0] dp_reg [NREG];
  logic [15:0]   dp_prod = '0;
  logic [7:0]    dp_f = '0;

  always @(posedge clk) begin
    for (int j = 0; j < NREG; j++) if (load[j]) dp_reg[j] <= next_in;
    if (mul_en) dp_prod <= dp_reg[oh_idx(mul_sel_a)] * dp_reg[oh_idx(mul_sel_b)];
    if (acc_clr) dp_f <= '0;
    else if (add_en) dp_f <= dp_f + dp_prod[7:0];
  end

  logic [NREG-1:0] exp_load [$];
  logic [DW-1:0]   exp_data [$];
  logic [NREG-1:0] exp_sa [$];
  logic [NREG-1:0] exp_sb [$];
  logic [7:0]      exp_f [$];

  int add_cnt = 0;
  int mul_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (load != '0) begin
        if (exp_load.size() == 0) check_val("load_unexpected", load, '0);
        else begin
          check_val("load_onehot", load, exp_load.pop_front());
          check_val("load_data", next_in, exp_data.pop_front());
        end
      end
      if (mul_en) begin
        mul_cnt++;
        if (exp_sa.size() == 0) check_val("mul_unexpected", mul_en, 1'b0);
        else begin
          check_val("mul_sel_a", mul_sel_a, exp_sa.pop_front());
          check_val("mul_sel_b", mul_sel_b, exp_sb.pop_front());
        end
      end else if ((mul_sel_a | mul_sel_b) != '0) begin
        check_val("sel_outside_mac", {mul_sel_a, mul_sel_b}, '0);
      end
      if (add_en) add_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_f.size() == 0) check_val("done_unexpected", done, 1'b0);
        else check_val("f_mod256", dp_f, exp_f.pop_front());
      end
    end
  end

  task automatic flush_queues();
    exp_load.delete();
    exp_data.delete();
    exp_sa.delete();
    exp_sb.delete();
    exp_f.delete();
  endtask

  task automatic run_case(input string name, input bit gaps, input bit pulses,
                          input int kill_at, input int abort_beats, input bit rand_data);
    logic [DW-1:0] d [NREG];
    logic [15:0]   pr;
    logic [7:0]    fexp;
    int i, c, t0, d0, a0, m0, exp_done_at, done_at;
    bit acc, finished, cut, aborted;

    fexp = '0;
    for (int j = 0; j < NREG; j++) d[j] = rand_data ? DW'($urandom_range(0, 255)) : DW'(j + 1);
    for (int p = 0; p < NPAIR; p++) begin
      pr = d[2*p] * d[2*p+1];
      fexp = fexp + pr[7:0];
    end
    cut = (kill_at != 0) || (abort_beats != 0);
    exp_done_at = gaps ? 26 : 17;
    done_at = -1;

    for (int j = 0; j < NREG; j++) begin
      exp_load.push_back(NREG'(1) << j);
      exp_data.push_back(d[j]);
    end
    for (int p = 0; p < NPAIR; p++) begin
      exp_sa.push_back(NREG'(1) << (2*p));
      exp_sb.push_back(NREG'(1) << (2*p + 1));
    end
    if (!cut) exp_f.push_back(fexp);

    @(posedge clk); #1;
    d0 = done_cnt; a0 = add_cnt; m0 = mul_cnt;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = d[0];
    @(negedge clk);
    t0 = cyc;
    check_val({name, "_acc_clr"}, acc_clr, 1'b1);
    check_val({name, "_start_state"}, state, ST_IDLE);
    acc = in_valid && in_ready;
    i = 0; finished = 1'b0; aborted = 1'b0;

    for (int g = 0; g < 120 && !finished; g++) begin
      @(posedge clk); #1;
      c = cyc - t0;
      if (acc) i++;
      start = pulses && (c == 3 || c == 12 || c == 17);
      in_valid = (i < NREG) && (!gaps || (c % 2 == 1));
      in_data = (i < NREG) ? d[i] : '0;
`ifdef VSEQ_ABORT_EN
      if (abort_beats != 0 && i == abort_beats && state == ST_LOAD) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
`endif
      @(negedge clk);
      acc = in_valid && in_ready;
`ifdef VSEQ_ABORT_EN
      if (aborted) begin
        check_val({name, "_abort_ready"}, in_ready, 1'b0);
        check_val({name, "_abort_load"}, load, '0);
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_val({name, "_abort_idle"}, {busy, state}, '0);
        finished = 1'b1;
      end
`endif
      if (kill_at != 0 && c == kill_at && !finished) begin
        check_val({name, "_kill_state"}, state, ST_MAC);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_val({name, "_kill_idle"}, {state, mul_en, add_en, busy, done}, '0);
        finished = 1'b1;
      end
      if (done && !finished) begin
        done_at = c;
        check_val({name, "_done_cycle"}, c, exp_done_at);
        finished = 1'b1;
      end
    end

    if (!finished) check_val({name, "_timeout"}, 1'b0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    if (cut) begin
      repeat (20) @(posedge clk);
      #1;
      check_val({name, "_no_done"}, done_cnt - d0, 0);
      flush_queues();
    end else begin
      @(negedge clk);
      check_val({name, "_back_idle"}, {busy, state}, '0);
      repeat (3) @(posedge clk);
      #1;
      check_val({name, "_done_count"}, done_cnt - d0, 1);
      check_val({name, "_add_count"}, add_cnt - a0, NPAIR);
      check_val({name, "_mul_count"}, mul_cnt - m0, NPAIR);
      check_val({name, "_queues_left"},
                exp_load.size() + exp_sa.size() + exp_f.size(), 0);
    end
    $display("run %-10s beats=%0d done_at=%0d f_expected=%0d dones=%0d", name, i, done_at,
             fexp, done_cnt - d0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_state", state, ST_IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check_val("idle_outs", {in_ready, load, mul_en, mul_sel_a, mul_sel_b,
                              add_en, acc_clr, busy, done}, '0);
      check_val("idle_state", state, ST_IDLE);
    end

    run_case("b2b",        1'b0, 1'b0, 0,  0, 1'b0);
    run_case("gaps",       1'b1, 1'b0, 0,  0, 1'b0);
    run_case("rand",       1'b0, 1'b0, 0,  0, 1'b1);
    run_case("kill",       1'b0, 1'b0, 13, 0, 1'b1);
    run_case("after_kill", 1'b0, 1'b0, 0,  0, 1'b1);
    run_case("pulses",     1'b0, 1'b1, 0,  0, 1'b1);
`ifdef VSEQ_ABORT_EN
    run_case("abort",      1'b0, 1'b0, 0,  4, 1'b1);
    run_case("post_abort", 1'b1, 1'b0, 0,  0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog expired");
  end

endmodule
